// File: rtl/mux4_scan_ctrl_if.sv
// mux4_scan_ctrl_if: scan request, mux select/sample and result handshake bundle
//  slave  : the scan controller side
//  master : the requester / downstream / mux side
interface mux4_scan_ctrl_if;
  logic       start_in;
  logic [3:0] en_mask_in;
  logic       mux_y_in;
  logic [1:0] sel_out;
  logic       busy_out;
  logic [3:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic       overrun_out;
  modport slave (
    input  start_in, en_mask_in, mux_y_in, ready_in,
    output sel_out, busy_out, data_out, valid_out, overrun_out
  );
  modport master (
    output start_in, en_mask_in, mux_y_in, ready_in,
    input  sel_out, busy_out, data_out, valid_out, overrun_out
  );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: steps a 4:1 mux select over enabled channels and returns the sampled bits as one word
//  clock_in, reset_in : rising-edge clock, synchronous active-high reset
//  bus.start_in/en_mask_in : scan request and channel enables (latched at start)
//  bus.sel_out/mux_y_in    : mux select out, mux output sampled back
//  bus.data_out/valid_out/ready_in : result word handshake, held until accepted
//  bus.busy_out : scan in progress; bus.overrun_out : sticky start-while-busy
module mux4_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input logic clock_in,
  input logic reset_in,
  mux4_scan_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t             state_q;
  logic [3:0]         mask_q, shadow_q, data_q, hi;
  logic [1:0]         sel_q, first, nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic               valid_q, ovr_q;
  // first: lowest enabled channel of the incoming mask
  // nxt:   lowest latched channel strictly above the current one (hi==0 means none left)
  always_comb begin
    first = '0;
    nxt = '0;
    hi = mask_q & ~((4'd2 << sel_q) - 4'd1);
    for (int i = 3; i >= 0; i--) begin
      if (bus.en_mask_in[i]) first = 2'(i);
      if (hi[i]) nxt = 2'(i);
    end
  end
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (bus.start_in && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (bus.start_in && bus.en_mask_in != 4'd0) begin
          mask_q   <= bus.en_mask_in;
          sel_q    <= first;
          cnt_q    <= CNT_W'(DWELL - 1);
          shadow_q <= '0;
          state_q  <= SCAN;
        end
        SCAN: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else begin
          shadow_q[sel_q] <= bus.mux_y_in;
          if (hi != 4'd0) begin
            sel_q <= nxt;
            cnt_q <= CNT_W'(DWELL - 1);
          end else begin
            data_q  <= shadow_q | (4'(bus.mux_y_in) << sel_q);
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (bus.ready_in) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.sel_out     = sel_q;
  assign bus.busy_out    = state_q != IDLE;
  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.overrun_out = ovr_q;
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: randomized and directed scans of DWELL=2 and DWELL=1 controllers against a channel-list model
module tb_mux4_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic [3:0] en_mask = '0;
  logic [3:0] a_in = '0;
  logic       start[2] = '{1'b0, 1'b0};
  logic       ready[2] = '{1'b0, 1'b0};
  logic [1:0] sel[2];
  logic       busy[2], valid[2], ovr[2];
  logic [3:0] data[2];
  logic       ov_exp[2] = '{1'b0, 1'b0};
  int         n_chk = 0, n_pass = 0;
  mux4_scan_ctrl_if ba();
  mux4_scan_ctrl_if bb();
  mux4_scan_ctrl #(.DWELL(2), .CNT_W(4)) dut_a (.clock_in(clk), .reset_in(reset_in), .bus(ba));
  mux4_scan_ctrl #(.DWELL(1), .CNT_W(4)) dut_b (.clock_in(clk), .reset_in(reset_in), .bus(bb));
  // each controller drives its own copy of the combinational 4:1 mux over a_in
  assign ba.start_in = start[0];
  assign ba.en_mask_in = en_mask;
  assign ba.ready_in = ready[0];
  assign ba.mux_y_in = a_in[ba.sel_out];
  assign bb.start_in = start[1];
  assign bb.en_mask_in = en_mask;
  assign bb.ready_in = ready[1];
  assign bb.mux_y_in = a_in[bb.sel_out];
  assign sel[0] = ba.sel_out;
  assign busy[0] = ba.busy_out;
  assign valid[0] = ba.valid_out;
  assign ovr[0] = ba.overrun_out;
  assign data[0] = ba.data_out;
  assign sel[1] = bb.sel_out;
  assign busy[1] = bb.busy_out;
  assign valid[1] = bb.valid_out;
  assign ovr[1] = bb.overrun_out;
  assign data[1] = bb.data_out;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Model: the select visits every enabled channel in ascending order, DWELL cycles each;
  // the result is a & m once the list is exhausted.
  task automatic run_scan(input int u, input logic [3:0] m, input logic [3:0] a,
                          input int dly, input int ov_at);
    int dw = (u == 1) ? 1 : 2;
    int q[$];
    for (int i = 0; i < 4; i++)
      if (m[i]) for (int r = 0; r < dw; r++) q.push_back(i);
    en_mask = m;
    a_in = a;
    start[u] = 1'b1;
    step();
    start[u] = 1'b0;
    en_mask = 4'($urandom);
    if (m == 4'd0) begin
      check("zero_busy", busy[u], 0);
      check("zero_valid", valid[u], 0);
      check("zero_ovr", ovr[u], ov_exp[u]);
      return;
    end
    check("start_busy", busy[u], 1);
    check("start_sel", sel[u], q[0]);
    check("start_valid", valid[u], 0);
    for (int k = 1; k <= q.size(); k++) begin
      if (k == ov_at) begin
        start[u] = 1'b1;
        ov_exp[u] = 1'b1;
      end
      ready[u] = 1'($urandom);
      step();
      start[u] = 1'b0;
      ready[u] = 1'b0;
      en_mask = 4'($urandom);
      if (k < q.size()) begin
        check("scan_sel", sel[u], q[k]);
        check("scan_valid", valid[u], 0);
      end else begin
        check("done_valid", valid[u], 1);
        check("done_data", data[u], a & m);
        check("done_sel", sel[u], q[q.size()-1]);
      end
    end
    for (int d = 0; d < dly; d++) begin
      step();
      check("hold_valid", valid[u], 1);
      check("hold_data", data[u], a & m);
      check("hold_busy", busy[u], 1);
    end
    ready[u] = 1'b1;
    step();
    ready[u] = 1'b0;
    check("acc_valid", valid[u], 0);
    check("acc_busy", busy[u], 0);
    check("acc_data", data[u], a & m);
    check("ovr", ovr[u], ov_exp[u]);
  endtask
  initial begin
    step();
    step();
    for (int u = 0; u < 2; u++) begin
      check("rst_sel", sel[u], 0);
      check("rst_data", data[u], 0);
      check("rst_valid", valid[u], 0);
      check("rst_busy", busy[u], 0);
      check("rst_ovr", ovr[u], 0);
    end
    reset_in = 1'b0;
    step();
    run_scan(0, 4'hF, 4'b1010, 0, 0);
    run_scan(0, 4'b0101, 4'b1111, 0, 0);
    run_scan(0, 4'b0110, 4'b0100, 5, 0);
    run_scan(0, 4'h0, 4'hF, 0, 0);
    run_scan(1, 4'h8, 4'hF, 0, 0);
    run_scan(1, 4'h8, 4'h7, 2, 0);
    run_scan(1, 4'hB, 4'h9, 1, 0);
    run_scan(0, 4'hF, 4'b0011, 0, 3);
    run_scan(1, 4'h5, 4'h4, 0, 2);
    for (int t = 0; t < 25; t++) begin
      int u = $urandom_range(0, 1);
      logic [3:0] m = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      run_scan(u, m, 4'($urandom), $urandom_range(0, 5),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end
    en_mask = 4'hF;
    a_in = 4'hF;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (3) step();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    ov_exp = '{1'b0, 1'b0};
    check("mrst_busy", busy[0], 0);
    check("mrst_sel", sel[0], 0);
    check("mrst_data", data[0], 0);
    check("mrst_ovr", ovr[0], 0);
    for (int k = 0; k < 10; k++) begin
      step();
      check("mrst_novalid", valid[0], 0);
    end
    run_scan(0, 4'h9, 4'h8, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
